// File: rtl/mul_arbiter.sv
// mul_arbiter
//   Round-robin scheduler that shares a single sequential multiplier among
//   four requesters. One requester is served at a time through a full
//   four-phase start/ack handshake. The product is returned with a one-cycle
//   done pulse.
//
//   Optional feature: define MUL_ARB_TIMEOUT_EN to enable a watchdog. A
//   request the multiplier never acknowledges is then abandoned after TIMEOUT
//   cycles. That request completes with rezultat = 0 and err pulsing with done.
//
// Ports
//   Clk           in   rising-edge clock
//   Rst_n         in   asynchronous active-low reset
//   req[3:0]      in   level request per requester, held until its done
//   op_a, op_b    in   packed operands, requester i at [i*WIDTH +: WIDTH]
//   grant[3:0]    out  one-hot, requester being served (issue..completion)
//   done[3:0]     out  one-hot one-cycle completion pulse
//   rezultat      out  captured product, valid with done
//   busy          out  state is not IDLE
//   err           out  watchdog pulse coincident with done (0 without macro)
//   mul_start     out  start to multiplier
//   mul_a, mul_b  out  operands to multiplier, stable while mul_start is high
//   mul_rezultat  in   multiplier product
//   mul_ack       in   multiplier completion
//
// States
//   state    | meaning
//   IDLE     | choose the next eligible requester and issue it
//   WAIT_ACK | mul_start high, waiting for mul_ack to rise
//   RELEASE  | mul_start low, waiting for mul_ack to fall, then done
module mul_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   op_a,
  input  logic [4*WIDTH-1:0]   op_b,
  output logic [3:0]           grant,
  output logic [3:0]           done,
  output logic [2*WIDTH-1:0]   rezultat,
  output logic                 busy,
  output logic                 err,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_rezultat,
  input  logic                 mul_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mul_arbiter: TIMEOUT must be at least 1");
  end

  state_t               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           idx_q, idx_d;
  logic [3:0]           grant_d, done_d;
  logic [2*WIDTH-1:0]   rez_d;
  logic                 start_d;
  logic [WIDTH-1:0]     a_d, b_d;

  logic [3:0]           elig;
  logic                 found;
  logic [1:0]           sel;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_d;
`endif

  // The done mask keeps a requester that is still holding req during its own
  // done cycle from being granted again immediately.
  assign elig = req & ~done;
  assign busy = (state_q != IDLE);

  // Round-robin search starting one past the last served index.
  always_comb begin
    logic [1:0] cand;
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant;
    done_d  = '0;
    rez_d   = rezultat;
    start_d = mul_start;
    a_d     = mul_a;
    b_d     = mul_b;
`ifdef MUL_ARB_TIMEOUT_EN
    tmr_d   = tmr_q;
    err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = 4'b0001 << sel;
          idx_d   = sel;
          a_d     = op_a[sel*WIDTH +: WIDTH];
          b_d     = op_b[sel*WIDTH +: WIDTH];
          start_d = 1'b1;
          state_d = WAIT_ACK;
`ifdef MUL_ARB_TIMEOUT_EN
          tmr_d   = TMR_LOAD;
`endif
        end
      end
      WAIT_ACK: begin
        if (mul_ack) begin
          rez_d   = mul_rezultat;
          start_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Completing only after ack falls guarantees the multiplier is idle
        // before the next issue.
        if (!mul_ack) begin
          done_d  = grant;
          grant_d = '0;
          ptr_d   = idx_q;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase

`ifdef MUL_ARB_TIMEOUT_EN
    // Watchdog overrides normal progress once the budget is spent.
    if (state_q != IDLE) begin
      if (tmr_q == '0) begin
        done_d  = grant;
        err_d   = 1'b1;
        grant_d = '0;
        start_d = 1'b0;
        rez_d   = '0;
        ptr_d   = idx_q;
        state_d = IDLE;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd3;
      idx_q     <= 2'd0;
      grant     <= '0;
      done      <= '0;
      rezultat  <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant     <= grant_d;
      done      <= done_d;
      rezultat  <= rez_d;
      mul_start <= start_d;
      mul_a     <= a_d;
      mul_b     <= b_d;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tmr_q <= '0;
      err   <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err   <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter
//   Directed bench for mul_arbiter. A small multiplier stub acknowledges a few
//   cycles after mul_start and drops ack once mul_start falls. The stub can be
//   disabled so that it never acknowledges. Expected values are hand-computed
//   constants. The timeout scenario is built only with MUL_ARB_TIMEOUT_EN.
module tb_mul_arbiter;
  localparam int W   = 4;
  localparam int TMO = 16;
  localparam int LAT = 3;

  logic           Clk = 1'b0;
  logic           Rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] op_a, op_b;
  logic [3:0]     grant, done;
  logic [2*W-1:0] rezultat;
  logic           busy, err, mul_start;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_rezultat;
  logic           mul_ack;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int multi_grant = 0;
  int lat = 0;
  logic stub_en;

  logic [3:0] d;
  logic [7:0] r;
  logic       e;
  int         n;
  int         n0;

  always #5 Clk = ~Clk;

  mul_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .grant(grant), .done(done), .rezultat(rezultat), .busy(busy), .err(err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_rezultat(mul_rezultat), .mul_ack(mul_ack)
  );

  // Multiplier stub, evaluated away from the active edge.
  always @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mul_ack = 1'b0;
      mul_rezultat = 8'hA5;
      lat = 0;
    end else if (mul_start && !mul_ack && stub_en) begin
      if (lat == LAT) begin
        mul_ack = 1'b1;
        mul_rezultat = mul_a * mul_b;
        lat = 0;
      end else begin
        lat++;
      end
    end else if (!mul_start && mul_ack) begin
      mul_ack = 1'b0;
      mul_rezultat = 8'h5A;
    end
  end

  always @(negedge Clk) begin
    if ($countones(grant) > 1) multi_grant++;
    if (done != 4'b0) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic wait_done(output logic [3:0] dd, output logic [7:0] rr, output logic ee);
    int i;
    i = 0;
    do begin
      @(negedge Clk);
      i++;
    end while (done == 4'b0 && i < 200);
    chk("done_seen", 32'(done != 4'b0), 1);
    dd = done;
    rr = rezultat;
    ee = err;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp4 [4];
    exp4 = '{8'd12, 8'd30, 8'd225, 8'd0};
    Rst_n = 1'b0; req = '0; op_a = '0; op_b = '0; stub_en = 1'b1;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_rez", rezultat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    // Single requester 0: 3*4
    set_ops(0, 4'd3, 4'd4);
    req = 4'b0001;
    @(negedge Clk);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_start", mul_start, 1);
    chk("t1_busy", busy, 1);
    chk("t1_mul_a", mul_a, 3);
    chk("t1_mul_b", mul_b, 4);
    wait_done(d, r, e);
    chk("t1_done", d, 4'b0001);
    chk("t1_rez", r, 12);
    chk("t1_err", e, 0);
    req = '0;
    @(negedge Clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_grant_after", grant, 0);
    chk("t1_start_after", mul_start, 0);

    // All four at once after reset: order 0,1,2,3
    do_reset();
    set_ops(0, 4'd3, 4'd4);
    set_ops(1, 4'd5, 4'd6);
    set_ops(2, 4'd15, 4'd15);
    set_ops(3, 4'd7, 4'd0);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_done(d, r, e);
      chk("t2_order", d, 32'(4'b0001 << k));
      chk("t2_rez", r, exp4[k]);
      req = req & ~d;
    end
    @(negedge Clk);
    chk("t2_idle", busy, 0);

    // Requesters 0 and 2 held: alternate, no re-grant in own done cycle
    set_ops(0, 4'd2, 4'd5);
    set_ops(2, 4'd9, 4'd9);
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_done(d, r, e);
      chk("t3_order", d, (k % 2 == 0) ? 4'b0001 : 4'b0100);
      chk("t3_rez", r, (k % 2 == 0) ? 10 : 81);
      if (k == 3) begin
        req = '0;
      end else begin
        @(negedge Clk);
        chk("t3_next_grant", grant, (k % 2 == 0) ? 4'b0100 : 4'b0001);
      end
    end

    // Operand change after issue must not affect the product
    set_ops(1, 4'd6, 4'd7);
    req = 4'b0010;
    @(negedge Clk);
    chk("t4_grant", grant, 4'b0010);
    set_ops(1, 4'd1, 4'd1);
    wait_done(d, r, e);
    chk("t4_done", d, 4'b0010);
    chk("t4_rez", r, 42);
    req = '0;

    // Reset during WAIT_ACK
    set_ops(3, 4'd5, 4'd5);
    req = 4'b1000;
    @(negedge Clk);
    chk("t5_grant", grant, 4'b1000);
    chk("t5_no_ack_yet", mul_ack, 0);
    n0 = done_cnt;
    #2 Rst_n = 1'b0;
    #1;
    chk("t5_grant_rst", grant, 0);
    chk("t5_start_rst", mul_start, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_done_rst", done, 0);
    chk("t5_rez_rst", rezultat, 0);
    req = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);
    chk("t5_no_done", done_cnt, n0);
    set_ops(1, 4'd4, 4'd3);
    req = 4'b0010;
    wait_done(d, r, e);
    chk("t5_done", d, 4'b0010);
    chk("t5_rez", r, 12);
    req = '0;
    @(negedge Clk);

`ifdef MUL_ARB_TIMEOUT_EN
    // Stub never acks: watchdog fires 16 cycles after issue
    stub_en = 1'b0;
    set_ops(2, 4'd1, 4'd1);
    set_ops(3, 4'd2, 4'd3);
    req = 4'b1100;
    @(negedge Clk);
    chk("t6_grant", grant, 4'b0100);
    n = 0;
    while (done == 4'b0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("t6_cycles", n, TMO);
    chk("t6_done", done, 4'b0100);
    chk("t6_err", err, 1);
    chk("t6_rez", rezultat, 0);
    req = 4'b1000;
    stub_en = 1'b1;
    wait_done(d, r, e);
    chk("t6_next_done", d, 4'b1000);
    chk("t6_next_rez", r, 6);
    chk("t6_next_err", e, 0);
    req = '0;
    @(negedge Clk);
`endif

    chk("multi_grant", multi_grant, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
